// File: rtl/stream_demux_pkg.sv
// -----------------------------------------------------------------------------
// stream_demux_pkg
// Shared types and constants for the stream_demux block.
//   state_t    : packet-routing FSM states (IDLE, PKT, DROP)
//   DROP_CNT_W : width of the optional dropped-beat counter
// -----------------------------------------------------------------------------
package stream_demux_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PKT  = 2'd1,
    DROP = 2'd2
  } state_t;

  localparam int DROP_CNT_W = 16;

endpackage

// File: rtl/stream_demux_oreg.sv
// -----------------------------------------------------------------------------
// stream_demux_oreg
// One-entry output holding register for stream_demux. Holds one beat (data,
// last, destination channel) and presents it as a one-hot per-channel valid.
// A load in the same cycle as a drain refills the entry without a bubble.
//
// Ports:
//   clk, rst_n : clock, synchronous active-low reset
//   load       : write ld_data/ld_last/ld_ch into the entry
//   ld_*       : beat to load
//   m_ready    : per-channel downstream ready
//   m_valid    : one-hot-or-zero per-channel valid
//   m_data     : held data
//   m_last     : held last flag
//   full       : entry holds a beat
//   drain      : held beat is accepted downstream this cycle
// -----------------------------------------------------------------------------
module stream_demux_oreg #(
  parameter int NUM_CH = 4,
  parameter int DATA_W = 8,
  parameter int SEL_W  = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [DATA_W-1:0] ld_data,
  input  logic              ld_last,
  input  logic [SEL_W-1:0]  ld_ch,
  input  logic [NUM_CH-1:0] m_ready,
  output logic [NUM_CH-1:0] m_valid,
  output logic [DATA_W-1:0] m_data,
  output logic              m_last,
  output logic              full,
  output logic              drain
);

  logic              full_q, full_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              last_q, last_d;
  logic [SEL_W-1:0]  ch_q,   ch_d;

  // Channel decode is done by comparison so non-power-of-two NUM_CH never
  // indexes past the end of m_ready.
  always_comb begin
    m_valid = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      m_valid[i] = full_q && (ch_q == SEL_W'(i));
    end
  end

  assign drain = |(m_valid & m_ready);

  always_comb begin
    full_d = full_q;
    data_d = data_q;
    last_d = last_q;
    ch_d   = ch_q;
    if (drain) begin
      full_d = 1'b0;
    end
    if (load) begin
      full_d = 1'b1;
      data_d = ld_data;
      last_d = ld_last;
      ch_d   = ld_ch;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      full_q <= 1'b0;
      data_q <= '0;
      last_q <= 1'b0;
      ch_q   <= '0;
    end else begin
      full_q <= full_d;
      data_q <= data_d;
      last_q <= last_d;
      ch_q   <= ch_d;
    end
  end

  assign m_data = data_q;
  assign m_last = last_q;
  assign full   = full_q;

endmodule

// File: rtl/stream_demux.sv
// -----------------------------------------------------------------------------
// stream_demux
// 1-to-NUM_CH stream demultiplexer with valid/ready handshake, per-packet
// channel lock and a registered output stage (1-cycle latency, full rate).
// The channel is sampled from s_sel on the first beat of a packet and held
// until s_last is accepted. Packets addressed to a non-existent channel are
// accepted and discarded, and flagged on the sticky drop_err.
//
// Optional feature (macro STREAM_DEMUX_DROP_CNT_EN): adds output drop_cnt,
// a saturating 16-bit count of discarded beats, cleared by err_clr.
//
// Ports:
//   clk, rst_n : clock, synchronous active-low reset
//   s_valid / s_ready / s_data / s_last / s_sel : upstream beat
//   m_valid (per channel) / m_ready (per channel) / m_data / m_last : outputs
//   busy       : a packet is in progress
//   lock_sel   : channel locked for the current/last packet
//   drop_err   : sticky, at least one beat was discarded
//   err_clr    : clears drop_err (and drop_cnt when present)
// -----------------------------------------------------------------------------
module stream_demux
  import stream_demux_pkg::*;
#(
  parameter  int NUM_CH = 4,
  parameter  int DATA_W = 8,
  localparam int SEL_W  = $clog2(NUM_CH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_last,
  input  logic [SEL_W-1:0]  s_sel,
  output logic [NUM_CH-1:0] m_valid,
  input  logic [NUM_CH-1:0] m_ready,
  output logic [DATA_W-1:0] m_data,
  output logic              m_last,
  output logic              busy,
  output logic [SEL_W-1:0]  lock_sel,
  output logic              drop_err,
  input  logic              err_clr
`ifdef STREAM_DEMUX_DROP_CNT_EN
  ,
  output logic [DROP_CNT_W-1:0] drop_cnt
`endif
);

  // One extra bit so NUM_CH itself is representable in the range check.
  localparam logic [SEL_W:0] NUM_CH_EXT = (SEL_W + 1)'(NUM_CH);

  state_t           state_q, state_d;
  logic [SEL_W-1:0] lock_sel_q, lock_sel_d;
  logic             drop_err_q, drop_err_d;

  logic             sel_ok;
  logic             accept;
  logic             load;
  logic             drop_beat;
  logic [SEL_W-1:0] ld_ch;
  logic             oreg_full;
  logic             oreg_drain;

  assign sel_ok = ({1'b0, s_sel} < NUM_CH_EXT);

  // Beats that are going to be discarded never need the output register,
  // so they are accepted regardless of downstream backpressure.
  always_comb begin
    s_ready = 1'b0;
    if (rst_n) begin
      if ((state_q == DROP) || ((state_q == IDLE) && !sel_ok)) begin
        s_ready = 1'b1;
      end else begin
        s_ready = !oreg_full || oreg_drain;
      end
    end
  end

  assign accept = s_valid & s_ready;

  always_comb begin
    state_d    = state_q;
    lock_sel_d = lock_sel_q;
    load       = 1'b0;
    drop_beat  = 1'b0;
    ld_ch      = lock_sel_q;
    if (accept) begin
      case (state_q)
        IDLE: begin
          if (sel_ok) begin
            load       = 1'b1;
            ld_ch      = s_sel;
            lock_sel_d = s_sel;
            if (!s_last) state_d = PKT;
          end else begin
            drop_beat = 1'b1;
            if (!s_last) state_d = DROP;
          end
        end
        PKT: begin
          load = 1'b1;
          if (s_last) state_d = IDLE;
        end
        DROP: begin
          drop_beat = 1'b1;
          if (s_last) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // A drop in the same cycle as err_clr keeps the flag set.
  always_comb begin
    drop_err_d = drop_err_q;
    if (err_clr)   drop_err_d = 1'b0;
    if (drop_beat) drop_err_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      lock_sel_q <= '0;
      drop_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      lock_sel_q <= lock_sel_d;
      drop_err_q <= drop_err_d;
    end
  end

  stream_demux_oreg #(
    .NUM_CH (NUM_CH),
    .DATA_W (DATA_W),
    .SEL_W  (SEL_W)
  ) u_oreg (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (load),
    .ld_data (s_data),
    .ld_last (s_last),
    .ld_ch   (ld_ch),
    .m_ready (m_ready),
    .m_valid (m_valid),
    .m_data  (m_data),
    .m_last  (m_last),
    .full    (oreg_full),
    .drain   (oreg_drain)
  );

  assign busy     = (state_q != IDLE);
  assign lock_sel = lock_sel_q;
  assign drop_err = drop_err_q;

`ifdef STREAM_DEMUX_DROP_CNT_EN
  logic [DROP_CNT_W-1:0] drop_cnt_q, drop_cnt_d;

  // Saturating count; a drop coinciding with err_clr restarts the count at 1.
  always_comb begin
    drop_cnt_d = drop_cnt_q;
    if (err_clr) begin
      drop_cnt_d = drop_beat ? DROP_CNT_W'(1) : '0;
    end else if (drop_beat && (drop_cnt_q != '1)) begin
      drop_cnt_d = drop_cnt_q + DROP_CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      drop_cnt_q <= '0;
    end else begin
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign drop_cnt = drop_cnt_q;
`endif

endmodule

// File: tb/tb_stream_demux.sv
// -----------------------------------------------------------------------------
// tb_stream_demux
// Two instances: u_dut3 (NUM_CH=3, exercises out-of-range drops) checked
// against a packet-level reference model plus a vector table, and u_dut4
// (NUM_CH=4) driven by hand-written multi-cycle sequences.
// -----------------------------------------------------------------------------
module tb_stream_demux;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // ---------------- NUM_CH = 3 instance ----------------
  logic       r3_n = 1'b0, v3 = 1'b0, l3 = 1'b0, clr3 = 1'b0;
  logic [7:0] d3 = '0;
  logic [1:0] sel3 = '0;
  logic [2:0] mr3 = '0;
  logic       rdy3, ml3, busy3, err3;
  logic [7:0] md3;
  logic [1:0] lock3;
  logic [2:0] mv3;
`ifdef STREAM_DEMUX_DROP_CNT_EN
  logic [15:0] cnt3;
`endif

  stream_demux #(.NUM_CH(3), .DATA_W(8)) u_dut3 (
    .clk(clk), .rst_n(r3_n), .s_valid(v3), .s_ready(rdy3), .s_data(d3),
    .s_last(l3), .s_sel(sel3), .m_valid(mv3), .m_ready(mr3), .m_data(md3),
    .m_last(ml3), .busy(busy3), .lock_sel(lock3), .drop_err(err3),
    .err_clr(clr3)
`ifdef STREAM_DEMUX_DROP_CNT_EN
    , .drop_cnt(cnt3)
`endif
  );

  // ---------------- NUM_CH = 4 instance ----------------
  logic       r4_n = 1'b0, v4 = 1'b0, l4 = 1'b0, clr4 = 1'b0;
  logic [7:0] d4 = '0;
  logic [1:0] sel4 = '0;
  logic [3:0] mr4 = '0;
  logic       rdy4, ml4, busy4, err4;
  logic [7:0] md4;
  logic [1:0] lock4;
  logic [3:0] mv4;
`ifdef STREAM_DEMUX_DROP_CNT_EN
  logic [15:0] cnt4;
`endif

  stream_demux #(.NUM_CH(4), .DATA_W(8)) u_dut4 (
    .clk(clk), .rst_n(r4_n), .s_valid(v4), .s_ready(rdy4), .s_data(d4),
    .s_last(l4), .s_sel(sel4), .m_valid(mv4), .m_ready(mr4), .m_data(md4),
    .m_last(ml4), .busy(busy4), .lock_sel(lock4), .drop_err(err4),
    .err_clr(clr4)
`ifdef STREAM_DEMUX_DROP_CNT_EN
    , .drop_cnt(cnt4)
`endif
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  // ---------------- reference model for u_dut3 ----------------
  // route: -1 = next beat starts a packet, -2 = rest of packet is discarded,
  // otherwise the channel the current packet is locked to.
  bit         h_v;
  logic [7:0] h_d;
  bit         h_l;
  int         h_ch;
  int         route;
  int         m_lock;
  bit         m_err;
  int         m_cnt;

  function automatic void model_reset();
    h_v = 1'b0; h_d = '0; h_l = 1'b0; h_ch = 0;
    route = -1; m_lock = 0; m_err = 1'b0; m_cnt = 0;
  endfunction

  function automatic bit model_ready();
    if (!r3_n) return 1'b0;
    if (route == -2) return 1'b1;
    if (route == -1 && int'(sel3) >= 3) return 1'b1;
    return !h_v || mr3[h_ch];
  endfunction

  function automatic void model_step();
    bit acc;
    bit drop;
    int dest;
    if (!r3_n) begin
      model_reset();
      return;
    end
    acc  = v3 && model_ready();
    drop = 1'b0;
    if (h_v && mr3[h_ch]) h_v = 1'b0;
    if (acc) begin
      if (route == -1) begin
        dest = (int'(sel3) < 3) ? int'(sel3) : -2;
        if (dest >= 0) m_lock = dest;
      end else begin
        dest = route;
      end
      if (dest >= 0) begin
        h_v = 1'b1; h_d = d3; h_l = l3; h_ch = dest;
      end else begin
        drop = 1'b1;
      end
      route = l3 ? -1 : dest;
    end
    if (clr3) begin
      m_err = drop;
      m_cnt = drop ? 1 : 0;
    end else if (drop) begin
      m_err = 1'b1;
      if (m_cnt < 65535) m_cnt++;
    end
  endfunction

  task automatic check3_regs();
    chk("d3_m_valid", 32'(mv3), h_v ? (32'd1 << h_ch) : 32'd0);
    chk("d3_m_data", 32'(md3), 32'(h_d));
    chk("d3_m_last", 32'(ml3), 32'(h_l));
    chk("d3_busy", 32'(busy3), 32'(route != -1));
    chk("d3_lock_sel", 32'(lock3), 32'(m_lock));
    chk("d3_drop_err", 32'(err3), 32'(m_err));
`ifdef STREAM_DEMUX_DROP_CNT_EN
    chk("d3_drop_cnt", 32'(cnt3), 32'(m_cnt));
`endif
  endtask

  // One cycle on u_dut3: drive, check s_ready, clock, check registered outputs.
  task automatic cyc3(input bit rn, input bit v, input logic [7:0] d, input bit l,
                      input logic [1:0] s, input logic [2:0] mr, input bit c,
                      output bit rdy_seen);
    r3_n = rn; v3 = v; d3 = d; l3 = l; sel3 = s; mr3 = mr; clr3 = c;
    #1;
    rdy_seen = rdy3;
    chk("d3_s_ready", 32'(rdy3), 32'(model_ready()));
    @(posedge clk);
    model_step();
    #1;
    check3_regs();
  endtask

  // One cycle on u_dut4 with an explicit expected s_ready.
  task automatic cyc4(input bit rn, input bit v, input logic [7:0] d, input bit l,
                      input logic [1:0] s, input logic [3:0] mr, input bit exp_rdy);
    r4_n = rn; v4 = v; d4 = d; l4 = l; sel4 = s; mr4 = mr;
    #1;
    chk("d4_s_ready", 32'(rdy4), 32'(exp_rdy));
    @(posedge clk);
    #1;
  endtask

  task automatic out4(input logic [3:0] mv, input logic [7:0] md, input bit ml,
                      input bit bz, input logic [1:0] lk);
    chk("d4_m_valid", 32'(mv4), 32'(mv));
    chk("d4_m_data", 32'(md4), 32'(md));
    chk("d4_m_last", 32'(ml4), 32'(ml));
    chk("d4_busy", 32'(busy4), 32'(bz));
    chk("d4_lock_sel", 32'(lock4), 32'(lk));
  endtask

  typedef struct {
    bit         v;
    logic [7:0] d;
    bit         l;
    logic [1:0] s;
    logic [2:0] mr;
    bit         c;
    bit         rdy;
    logic [2:0] mv;
    logic [7:0] md;
    bit         busy;
    bit         err;
  } vec_t;

  vec_t tbl [9];

  initial begin
    bit rs;
    model_reset();
    tbl[0] = '{1'b1, 8'hA1, 1'b0, 2'd1, 3'b111, 1'b0, 1'b1, 3'b010, 8'hA1, 1'b1, 1'b0};
    tbl[1] = '{1'b1, 8'hA2, 1'b1, 2'd0, 3'b111, 1'b0, 1'b1, 3'b010, 8'hA2, 1'b0, 1'b0};
    tbl[2] = '{1'b1, 8'hB1, 1'b1, 2'd3, 3'b111, 1'b0, 1'b1, 3'b000, 8'hA2, 1'b0, 1'b1};
    tbl[3] = '{1'b1, 8'hC1, 1'b0, 2'd3, 3'b111, 1'b0, 1'b1, 3'b000, 8'hA2, 1'b1, 1'b1};
    tbl[4] = '{1'b1, 8'hC2, 1'b1, 2'd0, 3'b000, 1'b0, 1'b1, 3'b000, 8'hA2, 1'b0, 1'b1};
    tbl[5] = '{1'b1, 8'hD1, 1'b0, 2'd2, 3'b000, 1'b1, 1'b1, 3'b100, 8'hD1, 1'b1, 1'b0};
    tbl[6] = '{1'b1, 8'hD2, 1'b1, 2'd0, 3'b000, 1'b0, 1'b0, 3'b100, 8'hD1, 1'b1, 1'b0};
    tbl[7] = '{1'b1, 8'hD2, 1'b1, 2'd0, 3'b100, 1'b0, 1'b1, 3'b100, 8'hD2, 1'b0, 1'b0};
    tbl[8] = '{1'b0, 8'h00, 1'b0, 2'd0, 3'b100, 1'b0, 1'b1, 3'b000, 8'hD2, 1'b0, 1'b0};

    @(posedge clk);
    #1;

    // ---- u_dut3: reset, then vector table ----
    cyc3(1'b0, 1'b1, 8'h5A, 1'b0, 2'd1, 3'b111, 1'b0, rs);
    chk("d3_reset_s_ready", 32'(rs), 32'd0);
    chk("d3_reset_m_valid", 32'(mv3), 32'd0);
    chk("d3_reset_busy", 32'(busy3), 32'd0);
    chk("d3_reset_drop_err", 32'(err3), 32'd0);

    for (int i = 0; i < 9; i++) begin
      cyc3(1'b1, tbl[i].v, tbl[i].d, tbl[i].l, tbl[i].s, tbl[i].mr, tbl[i].c, rs);
      chk($sformatf("tbl%0d_s_ready", i), 32'(rs), 32'(tbl[i].rdy));
      chk($sformatf("tbl%0d_m_valid", i), 32'(mv3), 32'(tbl[i].mv));
      chk($sformatf("tbl%0d_m_data", i), 32'(md3), 32'(tbl[i].md));
      chk($sformatf("tbl%0d_busy", i), 32'(busy3), 32'(tbl[i].busy));
      chk($sformatf("tbl%0d_drop_err", i), 32'(err3), 32'(tbl[i].err));
`ifdef STREAM_DEMUX_DROP_CNT_EN
      if (i == 2) chk("tbl2_drop_cnt", 32'(cnt3), 32'd1);
      if (i == 4) chk("tbl4_drop_cnt", 32'(cnt3), 32'd3);
`endif
    end

    // ---- u_dut3: err_clr in the same cycle as a new drop ----
    cyc3(1'b1, 1'b1, 8'hE0, 1'b1, 2'd3, 3'b111, 1'b0, rs);
    cyc3(1'b1, 1'b1, 8'hE1, 1'b1, 2'd3, 3'b111, 1'b1, rs);
    chk("clr_drop_s_ready", 32'(rs), 32'd1);
    chk("clr_drop_drop_err", 32'(err3), 32'd1);
    chk("clr_drop_m_valid", 32'(mv3), 32'd0);
`ifdef STREAM_DEMUX_DROP_CNT_EN
    chk("clr_drop_drop_cnt", 32'(cnt3), 32'd1);
`endif

    // ---- u_dut3: randomized traffic against the reference model ----
    for (int i = 0; i < 1500; i++) begin
      cyc3(($urandom_range(0, 199) != 0),
           ($urandom_range(0, 3) != 0),
           8'($urandom),
           ($urandom_range(0, 3) == 0),
           2'($urandom_range(0, 3)),
           3'($urandom),
           ($urandom_range(0, 15) == 0),
           rs);
    end

    // ---- u_dut4: hand sequences ----
    cyc4(1'b0, 1'b0, 8'h00, 1'b0, 2'd0, 4'hF, 1'b0);
    out4(4'b0000, 8'h00, 1'b0, 1'b0, 2'd0);

    // 3-beat packet to channel 2; s_sel changes mid-packet
    cyc4(1'b1, 1'b1, 8'h11, 1'b0, 2'd2, 4'hF, 1'b1);
    out4(4'b0100, 8'h11, 1'b0, 1'b1, 2'd2);
    cyc4(1'b1, 1'b1, 8'h22, 1'b0, 2'd0, 4'hF, 1'b1);
    out4(4'b0100, 8'h22, 1'b0, 1'b1, 2'd2);
    cyc4(1'b1, 1'b1, 8'h33, 1'b1, 2'd0, 4'hF, 1'b1);
    out4(4'b0100, 8'h33, 1'b1, 1'b0, 2'd2);
    cyc4(1'b1, 1'b0, 8'h00, 1'b0, 2'd0, 4'hF, 1'b1);
    out4(4'b0000, 8'h33, 1'b1, 1'b0, 2'd2);

    // Backpressure on channel 1 for 4 cycles, then drain + refill together
    cyc4(1'b1, 1'b1, 8'h44, 1'b0, 2'd1, 4'hD, 1'b1);
    out4(4'b0010, 8'h44, 1'b0, 1'b1, 2'd1);
    for (int i = 0; i < 4; i++) begin
      cyc4(1'b1, 1'b1, 8'h55, 1'b1, 2'd1, 4'hD, 1'b0);
      out4(4'b0010, 8'h44, 1'b0, 1'b1, 2'd1);
    end
    cyc4(1'b1, 1'b1, 8'h55, 1'b1, 2'd1, 4'hF, 1'b1);
    out4(4'b0010, 8'h55, 1'b1, 1'b0, 2'd1);
    cyc4(1'b1, 1'b0, 8'h00, 1'b0, 2'd0, 4'hF, 1'b1);
    out4(4'b0000, 8'h55, 1'b1, 1'b0, 2'd1);

    // Reset mid-packet with a held beat, then a fresh first beat to channel 3
    cyc4(1'b1, 1'b1, 8'h66, 1'b0, 2'd1, 4'h0, 1'b1);
    out4(4'b0010, 8'h66, 1'b0, 1'b1, 2'd1);
    cyc4(1'b0, 1'b1, 8'h67, 1'b0, 2'd1, 4'h0, 1'b0);
    out4(4'b0000, 8'h00, 1'b0, 1'b0, 2'd0);
    cyc4(1'b1, 1'b1, 8'h77, 1'b1, 2'd3, 4'hF, 1'b1);
    out4(4'b1000, 8'h77, 1'b1, 1'b0, 2'd3);
    chk("d4_drop_err", 32'(err4), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
